fifo_sized_count: RTL and testbench
===================================

FIFO_SIZED_COUNT -- requirements
Module: fifo_sized_count

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 4: capacity in entries, legal range 2..1024, any integer (not restricted to a power of two).
REQ-003 SHALL have parameter GUARDED, default 1: 1 = enqueue while full is an error even with a simultaneous DEQ; 0 = ENQ+DEQ while full is legal.
REQ-004 SHALL use clock CLK, input, 1 bit: all state updates on its rising edge.
REQ-005 SHALL use reset RST_N, input, 1 bit: synchronous, active-low.
REQ-006 SHALL have D_IN, input, WIDTH bits: enqueue data.
REQ-007 SHALL have ENQ, input, 1 bit: enqueue request.
REQ-008 SHALL have DEQ, input, 1 bit: dequeue request.
REQ-009 SHALL have CLR, input, 1 bit: synchronous flush.
REQ-010 SHALL have FULL_N, output, 1 bit: high when the FIFO can accept an entry.
REQ-011 SHALL have EMPTY_N, output, 1 bit: high when D_OUT is valid.
REQ-012 SHALL have D_OUT, output, WIDTH bits: head entry, first-word-fall-through.
REQ-013 SHALL have COUNT, output, CW bits: occupancy, where CW = ceil(log2(DEPTH+1)).
REQ-014 SHALL have ENQ_ERR, output, 1 bit: one-cycle pulse flagging a rejected enqueue.
REQ-015 SHALL have DEQ_ERR, output, 1 bit: one-cycle pulse flagging a rejected dequeue.

Function
REQ-016 SHALL drive FULL_N, EMPTY_N, COUNT, ENQ_ERR and DEQ_ERR directly from registers, with no combinational path from any input.
REQ-017 SHALL present the oldest entry on D_OUT whenever EMPTY_N=1; D_OUT is don't-care when EMPTY_N=0.
REQ-018 SHALL give 1-cycle latency: data enqueued into an empty FIFO appears on D_OUT with EMPTY_N=1 on the next cycle.
REQ-019 SHALL accept an enqueue when ENQ=1 and FULL_N=1, writing D_IN at the write pointer.
REQ-020 SHALL accept a dequeue when DEQ=1 and EMPTY_N=1, advancing the read pointer.
REQ-021 SHALL wrap read and write pointers from DEPTH-1 to 0, for any DEPTH.
REQ-022 SHALL apply COUNT+1 for an accepted ENQ alone, COUNT-1 for an accepted DEQ alone, and leave COUNT unchanged when both are accepted.
REQ-023 SHALL register FULL_N = (next COUNT != DEPTH) and EMPTY_N = (next COUNT != 0).
REQ-024 SHALL treat ENQ+DEQ while full as follows: GUARDED=0 -> both accepted, COUNT stays DEPTH, FULL_N stays 0; GUARDED=1 -> DEQ accepted, ENQ dropped, ENQ_ERR pulses, COUNT becomes DEPTH-1.
REQ-025 SHALL treat ENQ+DEQ while empty as: ENQ accepted, DEQ rejected, DEQ_ERR pulses, COUNT becomes 1.
REQ-026 SHALL treat ENQ while full without DEQ as: dropped, storage unchanged, ENQ_ERR pulses the next cycle.
REQ-027 SHALL treat DEQ while empty as: ignored, pointers unchanged, DEQ_ERR pulses the next cycle.
REQ-028 SHALL give CLR=1 priority over ENQ and DEQ: pointers=0, COUNT=0, EMPTY_N=0, FULL_N=1, no error pulses.
REQ-029 SHALL print, in simulation-only code, a warning naming the instance for each ENQ_ERR and DEQ_ERR event; this code is excluded from synthesis.

Reset
REQ-030 SHALL, while RST_N=0 at a clock edge, set pointers=0, COUNT=0, EMPTY_N=0, FULL_N=1, ENQ_ERR=0, DEQ_ERR=0, overriding CLR, ENQ and DEQ.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored entries; storage contents are not reset.
REQ-032 SHALL, unless initial blocks are disabled by compile define, initialise registers to the reset values at simulation time 0.
REQ-033 SHALL suppress error detection and warnings while RST_N=0.

Structure
REQ-034 SHALL place the count-width function (ceil(log2(n+1))) and the pointer-increment-with-wrap function in the shared FIFO package.
REQ-035 SHALL implement storage as one sub-module, fifo_store_mem (DEPTH x WIDTH, 1 write port, 1 asynchronous read port).
REQ-036 SHALL keep pointer, count, flag and error logic in the top module.

Verification
REQ-037 SHALL cover, with DEPTH=4 and WIDTH=8: enqueue 0x11,0x22,0x33,0x44 -> FULL_N=0 after the 4th, COUNT=4; dequeue 4 times -> D_OUT 0x11..0x44 in order, EMPTY_N=0, COUNT=0.
REQ-038 SHALL cover, with DEPTH=3: 10 interleaved enqueue/dequeue cycles -> pointers wrap, data order preserved, COUNT never exceeds 3.
REQ-039 SHALL cover ENQ+DEQ while full (COUNT=4): GUARDED=0 -> COUNT=4, new data at tail; GUARDED=1 -> COUNT=3, ENQ_ERR=1 for one cycle.
REQ-040 SHALL cover ENQ+DEQ while empty -> COUNT=1, DEQ_ERR=1 for one cycle, D_OUT=D_IN on the next cycle.
REQ-041 SHALL cover CLR together with ENQ at COUNT=2 -> COUNT=0, EMPTY_N=0, FULL_N=1, no error pulse.
REQ-042 SHALL cover RST_N=0 for one cycle at COUNT=3 -> all outputs at reset values on the next cycle; DEQ then raises DEQ_ERR.

Source files
------------

// File: rtl/fifo_sized_count_pkg.sv
// fifo_sized_count_pkg
//   Shared helpers for the sized FIFO: the occupancy counter width and the
//   pointer increment that wraps at an arbitrary (non power-of-two) depth.
package fifo_sized_count_pkg;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Next slot index, wrapping from depth-1 back to 0 for any depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_store_mem.sv
// fifo_store_mem
//   DEPTH x WIDTH storage array: one synchronous write port and one
//   asynchronous read port. Contents are never reset.
//   CLK     : write clock
//   WR_EN   : write strobe
//   WR_ADDR : write slot
//   WR_DATA : write data
//   RD_ADDR : read slot
//   RD_DATA : combinational read data
module fifo_store_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [WIDTH-1:0] RD_DATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  assign RD_DATA = mem[RD_ADDR];

endmodule

// File: rtl/fifo_sized_count.sv
// fifo_sized_count
//   First-word-fall-through FIFO of any depth with a registered occupancy
//   count and one-cycle error pulses for rejected enqueue/dequeue.
//   CLK, RST_N : clock, synchronous active-low reset
//   D_IN, ENQ  : enqueue data and request
//   DEQ        : dequeue request
//   CLR        : synchronous flush, wins over ENQ/DEQ
//   FULL_N     : can accept an entry
//   EMPTY_N    : D_OUT holds the oldest entry
//   D_OUT      : head entry
//   COUNT      : occupancy
//   ENQ_ERR    : pulse, previous enqueue rejected
//   DEQ_ERR    : pulse, previous dequeue rejected
module fifo_sized_count
  import fifo_sized_count_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 4,
  parameter  int GUARDED = 1,
  localparam int CW      = count_width(DEPTH),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             ENQ,
  input  logic             DEQ,
  input  logic             CLR,
  output logic             FULL_N,
  output logic             EMPTY_N,
  output logic [WIDTH-1:0] D_OUT,
  output logic [CW-1:0]    COUNT,
  output logic             ENQ_ERR,
  output logic             DEQ_ERR
);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_n_q, empty_n_q, enq_err_q, deq_err_q;
  logic          enq_ok, deq_ok, enq_err_d, deq_err_d;

  always_comb begin
    // Unguarded: a dequeue in the same cycle frees the slot the enqueue needs.
    enq_ok    = ENQ && (full_n_q || (GUARDED == 0 && DEQ));
    deq_ok    = DEQ && empty_n_q;
    enq_err_d = ENQ && !enq_ok;
    deq_err_d = DEQ && !deq_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_ok) wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (deq_ok) rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));

    count_d = count_q;
    if (enq_ok && !deq_ok)      count_d = count_q + CW'(1);
    else if (!enq_ok && deq_ok) count_d = count_q - CW'(1);
  end

  // Plain always so the time-zero initialisation below may share the variables.
  always @(posedge CLK) begin
    if (!RST_N || CLR) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      enq_err_q <= 1'b0;
      deq_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_n_q  <= (count_d != CW'(DEPTH));
      empty_n_q <= (count_d != '0);
      enq_err_q <= enq_err_d;
      deq_err_q <= deq_err_d;
    end
  end

`ifndef BSV_NO_INITIAL_BLOCKS
  initial begin
    wr_ptr_q  = '0;
    rd_ptr_q  = '0;
    count_q   = '0;
    full_n_q  = 1'b1;
    empty_n_q = 1'b0;
    enq_err_q = 1'b0;
    deq_err_q = 1'b0;
  end
`endif

  fifo_store_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .CLK     (CLK),
    .WR_EN   (enq_ok && RST_N && !CLR),
    .WR_ADDR (wr_ptr_q),
    .WR_DATA (D_IN),
    .RD_ADDR (rd_ptr_q),
    .RD_DATA (D_OUT)
  );

  assign FULL_N  = full_n_q;
  assign EMPTY_N = empty_n_q;
  assign COUNT   = count_q;
  assign ENQ_ERR = enq_err_q;
  assign DEQ_ERR = deq_err_q;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RST_N && !CLR) begin
      if (enq_err_d) $display("Warning: %m: enqueue while full dropped at %0t", $time);
      if (deq_err_d) $display("Warning: %m: dequeue while empty ignored at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sized_count.sv
module tb_fifo_sized_count;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] D_IN = '0;
  logic       ENQ = 1'b0, DEQ = 1'b0, CLR = 1'b0;

  logic       g_full_n, g_empty_n, g_enq_err, g_deq_err;
  logic [7:0] g_d_out;
  logic [2:0] g_count;
  logic       u_full_n, u_empty_n, u_enq_err, u_deq_err;
  logic [7:0] u_d_out;
  logic [2:0] u_count;
  logic       t_full_n, t_empty_n, t_enq_err, t_deq_err;
  logic [7:0] t_d_out;
  logic [1:0] t_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fifo_sized_count #(.WIDTH(8), .DEPTH(4), .GUARDED(1)) dut_g (
    .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
    .FULL_N(g_full_n), .EMPTY_N(g_empty_n), .D_OUT(g_d_out), .COUNT(g_count),
    .ENQ_ERR(g_enq_err), .DEQ_ERR(g_deq_err));

  fifo_sized_count #(.WIDTH(8), .DEPTH(4), .GUARDED(0)) dut_u (
    .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
    .FULL_N(u_full_n), .EMPTY_N(u_empty_n), .D_OUT(u_d_out), .COUNT(u_count),
    .ENQ_ERR(u_enq_err), .DEQ_ERR(u_deq_err));

  fifo_sized_count #(.WIDTH(8), .DEPTH(3), .GUARDED(1)) dut_3 (
    .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
    .FULL_N(t_full_n), .EMPTY_N(t_empty_n), .D_OUT(t_d_out), .COUNT(t_count),
    .ENQ_ERR(t_enq_err), .DEQ_ERR(t_deq_err));

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic e, input logic d, input logic c, input logic [7:0] din);
    ENQ = e; DEQ = d; CLR = c; D_IN = din;
    @(posedge CLK); #1;
    ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL reset_g: got %b want 1000000", {g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err});
    end
    checks++;
    if ({t_full_n, t_empty_n, t_count, t_enq_err, t_deq_err} !== 6'b1_0_00_0_0) begin
      errors++;
      $display("FAIL reset_3: got %b want 100000", {t_full_n, t_empty_n, t_count, t_enq_err, t_deq_err});
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, vals[i]);
      checks++;
      if (g_count !== 3'(i + 1) || g_full_n !== (i != 3) || g_empty_n !== 1'b1) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d full_n=%b empty_n=%b want count=%0d full_n=%b empty_n=1",
                 i, g_count, g_full_n, g_empty_n, i + 1, (i != 3));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g_d_out !== vals[i] || g_empty_n !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: d_out=%h empty_n=%b want d_out=%h empty_n=1", i, g_d_out, g_empty_n, vals[i]);
      end
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checks++;
    if ({g_full_n, g_empty_n, g_count, g_deq_err} !== 6'b1_0_000_0) begin
      errors++;
      $display("FAIL drained: got full_n/empty_n/count/deq_err=%b want 100000", {g_full_n, g_empty_n, g_count, g_deq_err});
    end
  endtask

  task automatic test_wrap_depth3();
    // Each row: {enq, deq, data}; never enqueues into a full FIFO.
    logic [9:0] ops [10];
    logic [7:0] model [$];
    ops = '{{2'b10, 8'hA1}, {2'b10, 8'hA2}, {2'b10, 8'hA3}, {2'b01, 8'h00}, {2'b11, 8'hA4},
            {2'b10, 8'hA5}, {2'b01, 8'h00}, {2'b11, 8'hA6}, {2'b11, 8'hA7}, {2'b01, 8'h00}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(ops[i][9], ops[i][8], 1'b0, ops[i][7:0]);
      if (ops[i][8] && model.size() > 0) void'(model.pop_front());
      if (ops[i][9]) model.push_back(ops[i][7:0]);
      checks++;
      if (t_count !== 2'(model.size()) || t_count > 2'd3 || t_full_n !== (model.size() != 3)
          || t_enq_err !== 1'b0 || t_deq_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_cnt_%0d: count=%0d full_n=%b errs=%b%b want count=%0d", i, t_count, t_full_n,
                 t_enq_err, t_deq_err, model.size());
      end
      if (model.size() > 0) begin
        checks++;
        if (t_d_out !== model[0] || t_empty_n !== 1'b1) begin
          errors++;
          $display("FAIL wrap_data_%0d: d_out=%h empty_n=%b want %h", i, t_d_out, t_empty_n, model[0]);
        end
      end
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({t_empty_n, t_count} !== 3'b0_00) begin
      errors++;
      $display("FAIL wrap_end: empty_n=%b count=%0d want 0 0", t_empty_n, t_count);
    end
  endtask

  task automatic test_full_enq_deq();
    logic [7:0] exp_u [4];
    exp_u = '{8'h20, 8'h30, 8'h40, 8'h50};
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b1, 1'b0, 1'b0, 8'h20);
    step(1'b1, 1'b0, 1'b0, 8'h30);
    step(1'b1, 1'b0, 1'b0, 8'h40);
    step(1'b1, 1'b1, 1'b0, 8'h50);
    checks++;
    if (g_count !== 3'd3 || g_enq_err !== 1'b1 || g_full_n !== 1'b1 || g_d_out !== 8'h20) begin
      errors++;
      $display("FAIL full_both_g: count=%0d enq_err=%b full_n=%b d_out=%h want 3 1 1 20",
               g_count, g_enq_err, g_full_n, g_d_out);
    end
    checks++;
    if (u_count !== 3'd4 || u_enq_err !== 1'b0 || u_full_n !== 1'b0 || u_d_out !== 8'h20) begin
      errors++;
      $display("FAIL full_both_u: count=%0d enq_err=%b full_n=%b d_out=%h want 4 0 0 20",
               u_count, u_enq_err, u_full_n, u_d_out);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (g_enq_err !== 1'b0 || g_count !== 3'd3) begin
      errors++;
      $display("FAIL enq_err_pulse: enq_err=%b count=%0d want 0 3", g_enq_err, g_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (u_d_out !== exp_u[i]) begin
        errors++;
        $display("FAIL tail_u_%0d: d_out=%h want %h", i, u_d_out, exp_u[i]);
      end
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    // The guarded instance held one fewer entry, so its fourth dequeue hit empty.
    checks++;
    if (g_deq_err !== 1'b1 || u_deq_err !== 1'b0 || u_count !== 3'd0) begin
      errors++;
      $display("FAIL drain_err: g_deq_err=%b u_deq_err=%b u_count=%0d want 1 0 0", g_deq_err, u_deq_err, u_count);
    end
  endtask

  task automatic test_empty_enq_deq();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    checks++;
    if (g_count !== 3'd1 || g_deq_err !== 1'b1 || g_enq_err !== 1'b0 || g_empty_n !== 1'b1 || g_d_out !== 8'h5A) begin
      errors++;
      $display("FAIL empty_both: count=%0d deq_err=%b enq_err=%b empty_n=%b d_out=%h want 1 1 0 1 5a",
               g_count, g_deq_err, g_enq_err, g_empty_n, g_d_out);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (g_deq_err !== 1'b0 || g_count !== 3'd1) begin
      errors++;
      $display("FAIL deq_err_pulse: deq_err=%b count=%0d want 0 1", g_deq_err, g_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h61 + i));
    step(1'b1, 1'b0, 1'b0, 8'h99);
    checks++;
    if (g_enq_err !== 1'b1 || g_count !== 3'd4 || g_full_n !== 1'b0 || g_d_out !== 8'h61) begin
      errors++;
      $display("FAIL overflow: enq_err=%b count=%0d full_n=%b d_out=%h want 1 4 0 61",
               g_enq_err, g_count, g_full_n, g_d_out);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (g_empty_n !== 1'b0 || g_deq_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: empty_n=%b deq_err=%b want 0 0", g_empty_n, g_deq_err);
    end
  endtask

  task automatic test_clr();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h03);
    checks++;
    if ({g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL clr: got %b want 1000000", {g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err});
    end
    step(1'b1, 1'b0, 1'b0, 8'h04);
    checks++;
    if (g_d_out !== 8'h04 || g_count !== 3'd1) begin
      errors++;
      $display("FAIL clr_after: d_out=%h count=%0d want 04 1", g_d_out, g_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h71);
    step(1'b1, 1'b0, 1'b0, 8'h72);
    step(1'b1, 1'b0, 1'b0, 8'h73);
    RST_N = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h74);
    RST_N = 1'b1;
    checks++;
    if ({g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err} !== 7'b1_0_000_0_0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 1000000", {g_full_n, g_empty_n, g_count, g_enq_err, g_deq_err});
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (g_deq_err !== 1'b1 || g_count !== 3'd0 || g_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_deq: deq_err=%b count=%0d empty_n=%b want 1 0 0", g_deq_err, g_count, g_empty_n);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_wrap_depth3();
    test_full_enq_deq();
    test_empty_enq_deq();
    test_overflow();
    test_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
